// File: rtl/byte_instr_assembler_pkg.sv
// Shared types and helpers for the byte instruction assembler.
package byte_instr_assembler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPER = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ILLEGAL = 3'd0,
    C0      = 3'd4,
    C1      = 3'd5,
    C2      = 3'd6,
    C3      = 3'd7
  } cls_t;

  // Classes 4..7 are legal; 0..3 are all treated as no-match.
  function automatic logic cls_legal(input logic [2:0] cls);
    return cls[2];
  endfunction

  // Number of operand bytes that follow an opcode of the given class.
  function automatic logic [1:0] cls_nops(input logic [2:0] cls);
    logic [1:0] n;
    n = 2'd0;
    case (cls)
      C0:      n = 2'd0;
      C1:      n = 2'd1;
      C2:      n = 2'd2;
      C3:      n = 2'd3;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/byte_operand_collector.sv
// Operand slot register: writes bytes into consecutive 8-bit slots.
module byte_operand_collector (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [7:0]  wr_byte,
  output logic [23:0] ops,
  output logic [1:0]  cnt
);

  // Slot write / clear; cnt is the index of the next free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops <= '0;
      cnt <= '0;
    end else if (clr) begin
      ops <= '0;
      cnt <= '0;
    end else if (wr_en) begin
      case (cnt)
        2'd0:    ops[7:0]   <= wr_byte;
        2'd1:    ops[15:8]  <= wr_byte;
        2'd2:    ops[23:16] <= wr_byte;
        default: ops        <= ops;
      endcase
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/byte_instr_assembler.sv
// Assembles opcode + operand bytes into one instruction with a
// valid/ready output, and counts illegal opcodes.
module byte_instr_assembler
  import byte_instr_assembler_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic [7:0]  dec_opc,
  input  logic [2:0]  dec_cls,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_opc,
  output logic [2:0]  out_cls,
  output logic [23:0] out_ops,
  output logic [1:0]  out_nops,
  output logic        err_illegal,
  output logic [7:0]  err_count
);

  state_t      state, state_nx;
  logic [7:0]  opc_q;
  logic [2:0]  cls_q;
  logic [1:0]  nops_q;
  logic [1:0]  op_cnt;
  logic        in_xfer;
  logic        out_xfer;
  logic        acc_legal;
  logic        acc_illegal;
  logic        op_wr;

  byte_operand_collector u_collector (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (acc_legal),
    .wr_en   (op_wr),
    .wr_byte (in_byte),
    .ops     (out_ops),
    .cnt     (op_cnt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state, handshakes and decoder-facing opcode.
  always_comb begin
    state_nx    = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    dec_opc     = opc_q;
    acc_legal   = 1'b0;
    acc_illegal = 1'b0;
    op_wr       = 1'b0;
    in_xfer     = 1'b0;
    out_xfer    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        dec_opc  = in_byte;
        in_xfer  = in_valid;
        if (in_xfer) begin
          if (cls_legal(dec_cls)) begin
            acc_legal = 1'b1;
            state_nx  = (cls_nops(dec_cls) == 2'd0) ? HOLD : OPER;
          end else begin
            acc_illegal = 1'b1;
          end
        end
      end
      OPER: begin
        in_ready = 1'b1;
        in_xfer  = in_valid;
        op_wr    = in_xfer;
        if (in_xfer && (op_cnt == nops_q - 2'd1)) state_nx = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        out_xfer  = out_ready;
        if (out_xfer) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Opcode, class and operand count latched at opcode accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_q  <= '0;
      cls_q  <= '0;
      nops_q <= '0;
    end else if (acc_legal) begin
      opc_q  <= in_byte;
      cls_q  <= dec_cls;
      nops_q <= cls_nops(dec_cls);
    end
  end

  // Illegal-opcode pulse and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal <= 1'b0;
      err_count   <= '0;
    end else begin
      err_illegal <= acc_illegal;
      if (acc_illegal && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  assign out_opc  = opc_q;
  assign out_cls  = cls_q;
  assign out_nops = nops_q;

endmodule

// File: tb/tb_byte_instr_assembler.sv
// Self-checking bench for byte_instr_assembler: vector table, directed
// corner sequences and a randomized run against a stream-parsing model.
module tb_byte_instr_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic [7:0]  dec_opc;
  logic [2:0]  dec_cls;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_opc;
  logic [2:0]  out_cls;
  logic [23:0] out_ops;
  logic [1:0]  out_nops;
  logic        err_illegal;
  logic [7:0]  err_count;

  logic [2:0]  cls_tab [256];

  int n_checks = 0;
  int n_fail   = 0;
  int err_exp  = 0;

  typedef struct {
    logic [7:0]  opc;
    logic [2:0]  cls;
    logic [23:0] ops_in;
    int          n_send;
    logic        exp_valid;
    logic [1:0]  exp_nops;
    logic [23:0] exp_ops;
  } vec_t;

  vec_t vt [10];

  byte_instr_assembler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_byte     (in_byte),
    .in_ready    (in_ready),
    .dec_opc     (dec_opc),
    .dec_cls     (dec_cls),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opc     (out_opc),
    .out_cls     (out_cls),
    .out_ops     (out_ops),
    .out_nops    (out_nops),
    .err_illegal (err_illegal),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Behavioural opcode decoder: table lookup.
  always_comb dec_cls = cls_tab[dec_opc];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    to_drive();
    to_drive();
    rst_n = 1'b1;
  endtask

  // Cycle-level reference: the input stream is parsed into instructions
  // (opcode, then class-determined number of operands); a completed
  // instruction blocks input until it is consumed.
  task automatic run_random(input int cycles, input int pv, input int pr, input bit legal_only);
    bit         m_pending = 1'b0;
    bit         m_collect = 1'b0;
    bit         m_pulse   = 1'b0;
    int         m_err     = 0;
    int         m_need    = 0;
    logic [7:0] m_opc     = '0;
    logic [2:0] m_cls     = '0;
    logic [7:0] q [$];
    logic [7:0]  p_opc = '0;
    logic [2:0]  p_cls = '0;
    logic [23:0] p_ops = '0;
    logic [1:0]  p_nops = '0;
    logic [2:0]  c;
    logic [7:0]  exp_dec;
    for (int i = 0; i < 256; i++)
      cls_tab[i] = legal_only ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 7));
    do_reset();
    for (int cyc = 0; cyc < cycles; cyc++) begin
      in_valid  = ($urandom_range(0, 99) < pv);
      in_byte   = 8'($urandom);
      out_ready = ($urandom_range(0, 99) < pr);
      @(negedge clk);
      exp_dec = m_pending ? p_opc : (m_collect ? m_opc : in_byte);
      chk("rnd_in_ready", in_ready, !m_pending);
      chk("rnd_out_valid", out_valid, m_pending);
      chk("rnd_dec_opc", dec_opc, exp_dec);
      chk("rnd_err_illegal", err_illegal, m_pulse);
      chk("rnd_err_count", err_count, m_err);
      if (m_pending) begin
        chk("rnd_out_opc", out_opc, p_opc);
        chk("rnd_out_cls", out_cls, p_cls);
        chk("rnd_out_ops", out_ops, p_ops);
        chk("rnd_out_nops", out_nops, p_nops);
      end
      m_pulse = 1'b0;
      if (m_pending) begin
        if (out_ready) m_pending = 1'b0;
      end else if (in_valid) begin
        if (!m_collect) begin
          c = cls_tab[in_byte];
          if (c < 3'd4) begin
            m_pulse = 1'b1;
            if (m_err < 255) m_err++;
          end else begin
            m_opc  = in_byte;
            m_cls  = c;
            m_need = int'(c) - 4;
            q.delete();
            if (m_need == 0) begin
              m_pending = 1'b1;
              p_opc = m_opc; p_cls = m_cls; p_ops = '0; p_nops = 2'd0;
            end else begin
              m_collect = 1'b1;
            end
          end
        end else begin
          q.push_back(in_byte);
          if (q.size() == m_need) begin
            m_collect = 1'b0;
            m_pending = 1'b1;
            p_opc = m_opc; p_cls = m_cls; p_nops = 2'(m_need);
            p_ops = '0;
            foreach (q[k]) p_ops[k*8 +: 8] = q[k];
          end
        end
      end
      to_drive();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) cls_tab[i] = 3'd0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_opc", out_opc, 0);
    chk("rst_out_cls", out_cls, 0);
    chk("rst_out_ops", out_ops, 0);
    chk("rst_out_nops", out_nops, 0);
    chk("rst_err_illegal", err_illegal, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_in_ready", in_ready, 1);
    to_drive();
    to_drive();
    rst_n = 1'b1;

    // opc, cls, operand bytes, bytes sent, valid, nops, ops
    vt[0] = '{8'hB0, 3'd4, 24'h000000, 0, 1'b1, 2'd0, 24'h000000};
    vt[1] = '{8'h9E, 3'd7, 24'h332211, 3, 1'b1, 2'd3, 24'h332211};
    vt[2] = '{8'h00, 3'd0, 24'h000000, 0, 1'b0, 2'd0, 24'h000000};
    vt[3] = '{8'h41, 3'd5, 24'h0000A5, 1, 1'b1, 2'd1, 24'h0000A5};
    vt[4] = '{8'h52, 3'd6, 24'h00BEEF, 2, 1'b1, 2'd2, 24'h00BEEF};
    vt[5] = '{8'h13, 3'd1, 24'h000000, 0, 1'b0, 2'd0, 24'h000000};
    vt[6] = '{8'h23, 3'd2, 24'h000000, 0, 1'b0, 2'd0, 24'h000000};
    vt[7] = '{8'h33, 3'd3, 24'h000000, 0, 1'b0, 2'd0, 24'h000000};
    vt[8] = '{8'h7F, 3'd7, 24'hFF00FF, 3, 1'b1, 2'd3, 24'hFF00FF};
    vt[9] = '{8'h01, 3'd4, 24'h000000, 0, 1'b1, 2'd0, 24'h000000};

    out_ready = 1'b1;
    foreach (vt[i]) begin
      cls_tab[vt[i].opc] = vt[i].cls;
      in_valid = 1'b1;
      in_byte  = vt[i].opc;
      @(negedge clk);
      chk("vec_opc_ready", in_ready, 1);
      chk("vec_dec_opc_idle", dec_opc, vt[i].opc);
      to_drive();
      for (int k = 0; k < vt[i].n_send; k++) begin
        in_byte = vt[i].ops_in[k*8 +: 8];
        @(negedge clk);
        chk("vec_oper_valid", out_valid, 0);
        chk("vec_dec_opc_oper", dec_opc, vt[i].opc);
        to_drive();
      end
      in_valid = 1'b0;
      @(negedge clk);
      if (vt[i].exp_valid) begin
        chk("vec_out_valid", out_valid, 1);
        chk("vec_out_opc", out_opc, vt[i].opc);
        chk("vec_out_cls", out_cls, vt[i].cls);
        chk("vec_out_nops", out_nops, vt[i].exp_nops);
        chk("vec_out_ops", out_ops, vt[i].exp_ops);
        chk("vec_hold_ready", in_ready, 0);
        to_drive();
        @(negedge clk);
        chk("vec_post_xfer_valid", out_valid, 0);
        to_drive();
      end else begin
        err_exp++;
        chk("vec_err_pulse", err_illegal, 1);
        chk("vec_err_no_valid", out_valid, 0);
        chk("vec_err_count", err_count, err_exp);
        to_drive();
        @(negedge clk);
        chk("vec_err_pulse_end", err_illegal, 0);
        to_drive();
      end
    end

    // Operand collection stalled by in_valid gaps.
    cls_tab[8'h9E] = 3'd7;
    in_valid = 1'b1; in_byte = 8'h9E; to_drive();
    in_byte = 8'h11; to_drive();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_no_valid", out_valid, 0);
      chk("stall_ready", in_ready, 1);
      chk("stall_dec_opc", dec_opc, 8'h9E);
      to_drive();
    end
    in_valid = 1'b1; in_byte = 8'h22; to_drive();
    in_byte = 8'h33; to_drive();
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_out_ops", out_ops, 24'h332211);
    chk("stall_out_nops", out_nops, 3);
    to_drive();

    // Output backpressure: cls 6 held for 5 cycles with in_valid asserted.
    out_ready = 1'b0;
    cls_tab[8'h66] = 3'd6;
    in_valid = 1'b1; in_byte = 8'h66; to_drive();
    in_byte = 8'h0A; to_drive();
    in_byte = 8'h0B; to_drive();
    in_byte = 8'hEE;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_opc", out_opc, 8'h66);
      chk("bp_cls", out_cls, 6);
      chk("bp_ops", out_ops, 24'h000B0A);
      chk("bp_nops", out_nops, 2);
      chk("bp_dec_opc", dec_opc, 8'h66);
      to_drive();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 1);
    to_drive();
    @(negedge clk);
    chk("bp_done_valid", out_valid, 0);
    chk("bp_done_ready", in_ready, 1);
    to_drive();

    // 300 back-to-back illegal opcodes saturate the counter.
    cls_tab[8'h00] = 3'd0;
    in_valid = 1'b1; in_byte = 8'h00;
    for (int k = 0; k < 300; k++) to_drive();
    in_valid = 1'b0;
    @(negedge clk);
    chk("sat_pulse_last", err_illegal, 1);
    chk("sat_count", err_count, 255);
    chk("sat_no_valid", out_valid, 0);
    to_drive();
    @(negedge clk);
    chk("sat_count_hold", err_count, 255);
    chk("sat_pulse_end", err_illegal, 0);
    to_drive();

    // Reset mid-operand collection discards the partial instruction.
    cls_tab[8'h52] = 3'd6;
    in_valid = 1'b1; in_byte = 8'h52; to_drive();
    in_byte = 8'h77; to_drive();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_opc", out_opc, 0);
    chk("mid_rst_cls", out_cls, 0);
    chk("mid_rst_ops", out_ops, 0);
    chk("mid_rst_nops", out_nops, 0);
    chk("mid_rst_err_count", err_count, 0);
    chk("mid_rst_ready", in_ready, 1);
    #1;
    rst_n = 1'b1;
    to_drive();
    cls_tab[8'hB4] = 3'd5;
    in_valid = 1'b1; in_byte = 8'hB4;
    @(negedge clk);
    chk("post_rst_dec_opc", dec_opc, 8'hB4);
    to_drive();
    in_byte = 8'h5A; to_drive();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_opc", out_opc, 8'hB4);
    chk("post_rst_cls", out_cls, 5);
    chk("post_rst_ops", out_ops, 24'h00005A);
    chk("post_rst_nops", out_nops, 1);
    to_drive();

    // Randomized traffic, then full-rate legal traffic for throughput.
    run_random(3000, 70, 60, 1'b0);
    run_random(400, 100, 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
